// File: rtl/lsu_mem_if.sv
// RV32I load/store unit: byte-enable/lane steering, load extension and a req/ack
// memory handshake with optional timeout. Define LSU_MISALIGN_TRAP_EN to trap misaligned h/w accesses.
module lsu_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  rsp_valid,
  output logic                  rsp_is_load,
  output logic [31:0]           rsp_rdata,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_err,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                  state_q;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [1:0]              off_q;
  logic [4:0]              rd_q;
  logic [CW-1:0]           cnt_q;
  logic                    req_ready_q, rsp_valid_q, rsp_is_load_q, rsp_err_q;
  logic [31:0]             rsp_rdata_q;
  logic [4:0]              rsp_rd_q;
  logic                    mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [3:0]              mem_be_q;
  logic [31:0]             mem_wdata_q;

  logic                    illegal_d, misalign_d, timeout_d;
  logic [3:0]              be_d;
  logic [31:0]             wdata_d, rdata_d, shifted_d;
  logic [7:0]              byte_d;
  logic [15:0]             half_d;

  // Request decode: legality, byte enables and replicated store data.
  always_comb begin
    illegal_d = (req_funct3 == 3'b011) || (req_funct3[2] && (req_funct3[1] || req_we));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign_d = 1'b0;
`endif
    case (req_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
  end

  // Load data lane selection and extension from the latched offset and width.
  always_comb begin
    shifted_d = mem_rdata >> {off_q, 3'b000};
    byte_d    = shifted_d[7:0];
    half_d    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rdata_d = {{24{byte_d[7]}}, byte_d};
      3'b001:  rdata_d = {{16{half_d[15]}}, half_d};
      3'b100:  rdata_d = {24'd0, byte_d};
      3'b101:  rdata_d = {16'd0, half_d};
      default: rdata_d = mem_rdata;
    endcase
  end

  assign timeout_d = (MAX_WAIT != 0) && (cnt_q == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      rd_q          <= 5'd0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_is_load_q <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_rd_q      <= 5'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            off_q       <= req_addr[1:0];
            rd_q        <= req_rd;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            // Rejected accesses skip the memory entirely and report an error.
            if (illegal_d || misalign_d) begin
              state_q       <= RESP;
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= 1'b1;
              rsp_is_load_q <= ~req_we;
              rsp_rd_q      <= req_we ? 5'd0 : req_rd;
              rsp_rdata_q   <= 32'd0;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        REQ: begin
          if (mem_ack || timeout_d) begin
            state_q       <= RESP;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= 4'd0;
            mem_wdata_q   <= 32'd0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= ~mem_ack;
            rsp_is_load_q <= ~we_q;
            rsp_rd_q      <= we_q ? 5'd0 : rd_q;
            rsp_rdata_q   <= (we_q || !mem_ack) ? 32'd0 : rdata_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q       <= IDLE;
          req_ready_q   <= 1'b1;
          rsp_valid_q   <= 1'b0;
          rsp_err_q     <= 1'b0;
          rsp_is_load_q <= 1'b0;
          rsp_rd_q      <= 5'd0;
          rsp_rdata_q   <= 32'd0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign stall       = (state_q != IDLE) || (req_valid && !req_ready_q);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_is_load = rsp_is_load_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_err     = rsp_err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: vector table plus hand-written latency,
// timeout, reset and misalignment sequences, with a response scoreboard.
module tb_lsu_mem_if;

  localparam int MW = 6;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_is_load, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_mem_if #(.ADDR_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_is_load(rsp_is_load), .rsp_rdata(rsp_rdata),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        isLoad;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] expRdata;
    logic        expErr;
    logic [3:0]  expBe;
    logic [31:0] expMemAddr;
    logic [31:0] expWdata;
  } vec_t;

  exp_t        expQ[$];
  vec_t        tbl[$];
  logic [31:0] memArr[0:255];
  int          total = 0, bad = 0;
  int          cyc = 0, acceptCyc = 0, rspCyc = 0, rspCount = 0;
  int          ackLatency = 1, reqCycles = 0;
  int          memReqCycles = 0, unstable = 0, stallBad = 0;
  logic        prevReq = 1'b0;
  logic [31:0] capAddr, capWdata;
  logic [3:0]  capBe;
  logic        capWe;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Variable-latency memory: acks in the ackLatency-th request cycle (0 = never).
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    for (int i = 0; i < 256; i++) memArr[i] = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        reqCycles++;
        if (ackLatency != 0 && reqCycles == ackLatency) begin
          mem_ack   = 1'b1;
          mem_rdata = memArr[mem_addr[9:2]];
          if (mem_we)
            for (int l = 0; l < 4; l++)
              if (mem_be[l]) memArr[mem_addr[9:2]][8*l +: 8] = mem_wdata[8*l +: 8];
        end
      end else begin
        reqCycles = 0;
      end
    end
  end

  // Response scoreboard and memory-side monitor.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rspCyc = cyc;
      rspCount++;
      if (expQ.size() == 0) begin
        check("unexpected rsp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("rsp_is_load", rsp_is_load, e.isLoad);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_rd", rsp_rd, e.rd);
        check("rsp_err", rsp_err, e.err);
      end
    end
    if (mem_req) begin
      memReqCycles++;
      if (!stall) stallBad++;
      if (!prevReq) begin
        capAddr = mem_addr; capBe = mem_be; capWdata = mem_wdata; capWe = mem_we;
      end else if (mem_addr !== capAddr || mem_be !== capBe ||
                   mem_wdata !== capWdata || mem_we !== capWe) begin
        unstable++;
      end
    end
    prevReq = mem_req;
  end

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd,
                               input logic [31:0] expRdata, input logic expErr, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready before issue", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    if (push) begin
      e.isLoad = ~we;
      e.rdata  = expRdata;
      e.rd     = we ? 5'd0 : rd;
      e.err    = expErr;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic checkOutput();
    int n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("response arrived", expQ.size(), 0);
  endtask

  initial begin
    int base, rc, ub, sb;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;

    //             we    f3      addr          wdata          rd     expRdata       err   be     memAddr      wdata
    tbl.push_back('{1'b1, 3'b010, 32'h0000_0000, 32'd50,        5'd1,  32'h0,         1'b0, 4'hF, 32'h000,     32'd50});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0000, 32'h0,         5'd2,  32'd50,        1'b0, 4'hF, 32'h000,     32'h0});
    tbl.push_back('{1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0,  32'h0,         1'b0, 4'h8, 32'h100,     32'hA5A5_A5A5});
    tbl.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0,         5'd3,  32'hFFFF_FFA5, 1'b0, 4'h8, 32'h100,     32'h0});
    tbl.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0,         5'd4,  32'h0000_00A5, 1'b0, 4'h8, 32'h100,     32'h0});
    tbl.push_back('{1'b1, 3'b010, 32'h0000_0000, 32'h8001_7FFF, 5'd1,  32'h0,         1'b0, 4'hF, 32'h000,     32'h8001_7FFF});
    tbl.push_back('{1'b0, 3'b001, 32'h0000_0002, 32'h0,         5'd5,  32'hFFFF_8001, 1'b0, 4'hC, 32'h000,     32'h0});
    tbl.push_back('{1'b0, 3'b101, 32'h0000_0002, 32'h0,         5'd6,  32'h0000_8001, 1'b0, 4'hC, 32'h000,     32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h0000_0000, 32'h0,         5'd7,  32'h0000_7FFF, 1'b0, 4'h3, 32'h000,     32'h0});
    tbl.push_back('{1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 5'd1,  32'h0,         1'b0, 4'hC, 32'h004,     32'hABCD_ABCD});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0004, 32'h0,         5'd8,  32'hABCD_0000, 1'b0, 4'hF, 32'h004,     32'h0});
    tbl.push_back('{1'b0, 3'b000, 32'h0000_0001, 32'h0,         5'd9,  32'h0000_007F, 1'b0, 4'h2, 32'h000,     32'h0});
    tbl.push_back('{1'b1, 3'b000, 32'h0000_0005, 32'h0000_003C, 5'd1,  32'h0,         1'b0, 4'h2, 32'h004,     32'h3C3C_3C3C});
    tbl.push_back('{1'b0, 3'b100, 32'h0000_0005, 32'h0,         5'd10, 32'h0000_003C, 1'b0, 4'h2, 32'h004,     32'h0});
    tbl.push_back('{1'b0, 3'b011, 32'h0000_0000, 32'h0,         5'd11, 32'h0,         1'b1, 4'h0, 32'h000,     32'h0});
    tbl.push_back('{1'b1, 3'b100, 32'h0000_0000, 32'h0,         5'd12, 32'h0,         1'b1, 4'h0, 32'h000,     32'h0});
    tbl.push_back('{1'b0, 3'b111, 32'h0000_0008, 32'h0,         5'd13, 32'h0,         1'b1, 4'h0, 32'h000,     32'h0});

    repeat (3) @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset stall", stall, 1'b0);
    check("reset mem_req", mem_req, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    rst = 1'b1;

    ackLatency = 1;
    foreach (tbl[i]) begin
      base = memReqCycles;
      applyStimulus(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rd,
                    tbl[i].expRdata, tbl[i].expErr, 1'b1);
      checkOutput();
      check($sformatf("vec%0d latency", i), rspCyc - acceptCyc, tbl[i].expErr ? 0 : 1);
      check($sformatf("vec%0d mem_req cycles", i), memReqCycles - base, tbl[i].expErr ? 0 : 1);
      if (!tbl[i].expErr) begin
        check($sformatf("vec%0d mem_be", i), capBe, tbl[i].expBe);
        check($sformatf("vec%0d mem_addr", i), capAddr, tbl[i].expMemAddr);
        check($sformatf("vec%0d mem_we", i), capWe, tbl[i].we);
        if (tbl[i].we) check($sformatf("vec%0d mem_wdata", i), capWdata, tbl[i].expWdata);
      end
    end

    // Ack delayed to the 5th request cycle.
    ackLatency = 5;
    base = memReqCycles; ub = unstable; sb = stallBad;
    applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 5'd14, 32'h8001_7FFF, 1'b0, 1'b1);
    checkOutput();
    check("delay5 latency", rspCyc - acceptCyc, 5);
    check("delay5 mem_req cycles", memReqCycles - base, 5);
    check("delay5 fields stable", unstable - ub, 0);
    check("delay5 stall held", stallBad - sb, 0);

    // No ack: timeout after MW request cycles.
    ackLatency = 0;
    base = memReqCycles;
    applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, 5'd15, 32'h0, 1'b1, 1'b1);
    checkOutput();
    check("timeout latency", rspCyc - acceptCyc, MW);
    check("timeout mem_req cycles", memReqCycles - base, MW);
    @(negedge clk);
    check("timeout mem_req dropped", mem_req, 1'b0);

    // Ack on the very cycle the timeout would fire: ack wins.
    ackLatency = MW;
    applyStimulus(1'b0, 3'b101, 32'h6, 32'h0, 5'd16, 32'h0000_ABCD, 1'b0, 1'b1);
    checkOutput();
    check("ack-at-timeout latency", rspCyc - acceptCyc, MW);

    // Reset while a request is outstanding.
    ackLatency = 0;
    rc = rspCount;
    applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, 5'd17, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre-reset mem_req", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async reset mem_req", mem_req, 1'b0);
    check("async reset req_ready", req_ready, 1'b1);
    check("async reset stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("no rsp after reset", rspCount - rc, 0);
    ackLatency = 1;
    applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, 5'd17, 32'hABCD_3C00, 1'b0, 1'b1);
    checkOutput();
    check("post-reset latency", rspCyc - acceptCyc, 1);

    // Misaligned word load.
    base = memReqCycles;
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, 5'd18, 32'h0, 1'b1, 1'b1);
    checkOutput();
    check("misalign no mem_req", memReqCycles - base, 0);
`else
    applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, 5'd18, 32'hABCD_3C00, 1'b0, 1'b1);
    checkOutput();
    check("misalign mem_req cycles", memReqCycles - base, 1);
    check("misalign mem_addr", capAddr, 32'h4);
    check("misalign mem_be", capBe, 4'hF);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
